cpu_state_dumper: RTL

- Debug-side consumer of the single-cycle CPU's display ports.
- On a start pulse it walks the CPU's debug read ports and streams the state out over a 32-bit valid/ready word stream:
  - snapshot of PC and instruction
  - all 32 GPRs
  - a window of data memory
- Replaces manual poking of `rf_addr`/`mem_addr` by the board display logic.
- Downstream sink is a UART or LCD formatter.

---
 rtl/dbg_pkg.sv | 6 +
 rtl/dump_out_reg.sv | 32 +++
 rtl/cpu_state_dumper.sv | 110 +++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types and constants for debug-side state streamers
package dbg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PC, S_INST, S_REG, S_MEM} dump_state_e;
  localparam logic [15:0] HDR_MAGIC = 16'hC0DE;
  localparam int GPR_COUNT = 32;
endpackage

// File: rtl/dump_out_reg.sv
// dump_out_reg: single skid-free valid/ready output register with load enable
module dump_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         ready_i,
  output logic         ld_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         last_o
);
  logic         valid_q, last_q;
  logic [W-1:0] data_q;
  assign ld_o    = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (ld_o) begin
      valid_q <= valid_i;
      data_q  <= data_i;
      last_q  <= valid_i && last_i;
    end
endmodule

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: streams PC/inst snapshot, all GPRs and a data-memory window on start
module cpu_state_dumper
  import dbg_pkg::*;
#(
  parameter int          MEM_WORDS = 8,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic        dump_last
);
  localparam logic [5:0]  MW       = 6'(MEM_WORDS);
  localparam logic [31:0] HDR_WORD = {HDR_MAGIC, 8'(GPR_COUNT), 8'(MEM_WORDS)};
  dump_state_e state_q;
  logic [31:0] pc_q, inst_q, mem_addr_q;
  logic [4:0]  rf_addr_q;
  logic [5:0]  mem_cnt_q;
  logic        ld, w_valid, w_last;
  logic [31:0] w_data;
  assign busy     = state_q != S_IDLE;
  assign rf_addr  = rf_addr_q;
  assign mem_addr = mem_addr_q;
  // state names the word currently held; the mux picks the word loaded next
  always_comb begin
    w_valid = 1'b1;
    w_last  = 1'b0;
    w_data  = rf_data;
    case (state_q)
      S_IDLE: begin
        w_valid = start;
        w_data  = HDR_WORD;
      end
      S_HDR:  w_data = pc_q;
      S_PC:   w_data = inst_q;
      S_INST: w_data = rf_data;
      S_REG: begin
        w_data = (rf_addr_q != 5'd0) ? rf_data : mem_data;
        w_last = rf_addr_q == 5'd0 && MW == 6'd1;
      end
      S_MEM: begin
        w_valid = mem_cnt_q != MW;
        w_data  = mem_data;
        w_last  = mem_cnt_q + 6'd1 == MW;
      end
      default: w_valid = 1'b0;
    endcase
  end
  // rf_addr_q reaching 0 again inside REG marks all GPRs loaded
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inst_q     <= '0;
      rf_addr_q  <= '0;
      mem_addr_q <= MEM_BASE;
      mem_cnt_q  <= '0;
    end else if (ld) begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_HDR;
          pc_q    <= cpu_pc;
          inst_q  <= cpu_inst;
        end
        S_HDR: state_q <= S_PC;
        S_PC:  state_q <= S_INST;
        S_INST: begin
          state_q   <= S_REG;
          rf_addr_q <= 5'd1;
        end
        S_REG: if (rf_addr_q != 5'd0) rf_addr_q <= rf_addr_q + 5'd1;
        else begin
          state_q    <= S_MEM;
          mem_addr_q <= mem_addr_q + 32'd4;
          mem_cnt_q  <= 6'd1;
        end
        S_MEM: if (mem_cnt_q == MW) begin
          state_q    <= S_IDLE;
          mem_addr_q <= MEM_BASE;
          mem_cnt_q  <= '0;
        end else begin
          mem_addr_q <= mem_addr_q + 32'd4;
          mem_cnt_q  <= mem_cnt_q + 6'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  dump_out_reg #(.W(32)) u_out (
    .clk     (clk),
    .resetn  (resetn),
    .valid_i (w_valid),
    .data_i  (w_data),
    .last_i  (w_last),
    .ready_i (dump_ready),
    .ld_o    (ld),
    .valid_o (dump_valid),
    .data_o  (dump_data),
    .last_o  (dump_last)
  );
endmodule
